id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the RV32IM pipeline, sitting between instruction fetch and execute. It splits the 32-bit instruction into opcode, func3 and func7, and generates the sign-extended immediate. It holds the 32×32 architectural register file, with two combinational read ports and one synchronous write port. All 32 registers are also exported for debug and observation.

## Interface
- Inst_Size, default 32: instruction, register and data width. Only 32 is supported.
- clk  in  1: rising-edge clock for register-file writes.
- rst_n  in  1: asynchronous, active-low reset.
- Inst  in  Inst_Size: instruction being decoded.
- wr_en  in  1: write-back enable from the WB stage.
- Imm_Sel  in  1: when 1, enables the U-type immediate.
- jal  in  1: forces J-format immediate decoding.
- write_data  in  Inst_Size: write-back value, written to rd = Inst[11:7].
- rs1_data, rs2_data  out  Inst_Size: contents of registers Inst[19:15] and Inst[24:20].
- Ext_Imm  out  Inst_Size: extended immediate.
- func7  out  7, func3  out  3, opcode  out  7: decoded instruction fields.
- x0 … x31  out  Inst_Size each: live register contents.

## Operation
- opcode = Inst[6:0], always.
- func3 = Inst[14:12]; forced to 0 for U-type (0110111, 0010111) and J-type (1101111).
- func7 = Inst[31:25] for R-type (0110011) and for OP-IMM shifts (0010011 with func3 001/101); 0 otherwise.
- Ext_Imm is selected by opcode; jal=1 overrides the selection to J-format:
  - I-format (0010011, 0000011, 1100111): sign-extended Inst[31:20].
  - S-format (0100011): sext{Inst[31:25], Inst[11:7]}.
  - B-format (1100011): sext{Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0}.
  - J-format: sext{Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0}.
  - U-format: {Inst[31:12], 12'b0} when Imm_Sel=1, else 0.
  - R-type and unknown opcodes: 0.
- Register write occurs only when all of the following hold:
  - wr_en=1;
  - rd≠0;
  - opcode is not S-type or B-type (these have no rd).
- x0 is hard-wired to 0; writes to it are discarded.
- Reads are combinational. Reading register 0 returns 0.

## Timing
- Decode outputs and read ports are combinational from Inst and the register contents; zero-cycle latency.
- A write commits on the rising edge of clk. The new value is visible on xN and on the read ports after that edge.
- When a write to register r coincides with a read of r: without bypass, the read returns the old value until the edge.
- rst_n low asynchronously clears all 32 registers to 0, including when asserted mid-write. Reset has priority over any same-edge write.
- Decode outputs do not depend on reset.

## Configuration
- REGFILE_BYPASS_EN defined: if a write is enabled to register r, rs1_data and rs2_data reading r return write_data in the same cycle (write-before-read forwarding). The x0 port is never bypassed.
- REGFILE_BYPASS_EN undefined: pure read-old-value behaviour; xN ports are never bypassed in either mode.

## Structure
- Package id_pkg contains:
  - opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - an imm_fmt_e enum: I, S, B, U, J, NONE.
- One sub-module, reg_file: 32×Inst_Size, 2 read ports, 1 write port, async active-low clear, debug bus. Immediate generation and field decode stay in id_stage.

## Test plan
- I-type write: Inst=0x00000313, write_data=0x313, wr_en=1, one clock edge -> opcode=0010011, func3=0, func7=0, Ext_Imm=0, x6=0x313.
- R-type: Inst=0x00002333, wr_en=1 -> func3=010, func7=0, Ext_Imm=0, x6=0x313. Repeat with Inst[31:25]=0100000 -> func7=0x20.
- JAL: Inst=0x0000036F, jal=1 -> opcode=1101111, func3=0, Ext_Imm=0, x6=write_data. Repeat with Inst=0x8000006F -> Ext_Imm=0xFFF00000.
- B/S without rd: Inst=0x00114063 and Inst=0x0000A023 with wr_en=1 -> func3=100 and 010 respectively, Ext_Imm=0, no register changes, x6 still 0x313.
- LUI: Inst=0x0000F337 -> func3=0, func7=0, and:
  - Imm_Sel=0 -> Ext_Imm=0;
  - Imm_Sel=1 -> Ext_Imm=0x0000F000.
- Reset and x0: load x6 and x31, then pulse rst_n low between edges -> all xN=0 immediately. A write to rd=0 leaves x0=0. With REGFILE_BYPASS_EN, a same-cycle read of the register being written returns write_data.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the id_stage slice: RV32 opcode constants and the
// immediate-format enumeration used by the immediate generator.
package id_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {I, S, B, U, J, NONE} imm_fmt_e;

    // Stores and branches carry no destination register.
    function automatic logic has_rd(input logic [6:0] opc);
        return (opc != OP_STORE) && (opc != OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32-entry register file: two combinational read ports, one synchronous write port,
// async active-low clear and a full debug bus. Optional forwarding: REGFILE_BYPASS_EN.
module reg_file #(
    parameter int Inst_Size = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_we,
    input  logic [4:0]                      i_waddr,
    input  logic [Inst_Size-1:0]            i_wdata,
    input  logic [4:0]                      i_raddr1,
    input  logic [4:0]                      i_raddr2,
    output logic [Inst_Size-1:0]            o_rdata1,
    output logic [Inst_Size-1:0]            o_rdata2,
    output logic [31:0][Inst_Size-1:0]      o_regs
);

    logic [Inst_Size-1:0] r_regs [32];
    logic                 w_commit;

    assign w_commit = i_we && (i_waddr != 5'd0);

    // NOTE: every entry is cleared by rst_n, so this stays a flop array rather
    // than an inferred RAM; entry 0 is never written and therefore reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) o_regs[i] = r_regs[i];
    end

`ifdef REGFILE_BYPASS_EN
    assign o_rdata1 = (w_commit && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = (w_commit && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];
`else
    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];
`endif

endmodule

// File: rtl/id_stage.sv
// RV32IM decode stage: field split, immediate generation and the architectural
// register file. Optional write-before-read forwarding: REGFILE_BYPASS_EN.
module id_stage
    import id_pkg::*;
#(
    parameter int Inst_Size = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [Inst_Size-1:0] Inst,
    input  logic                 wr_en,
    input  logic                 Imm_Sel,
    input  logic                 jal,
    input  logic [Inst_Size-1:0] write_data,
    output logic [Inst_Size-1:0] rs1_data,
    output logic [Inst_Size-1:0] rs2_data,
    output logic [Inst_Size-1:0] Ext_Imm,
    output logic [6:0]           func7,
    output logic [2:0]           func3,
    output logic [6:0]           opcode,
    output logic [Inst_Size-1:0] x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
    output logic [Inst_Size-1:0] x8,  x9,  x10, x11, x12, x13, x14, x15,
    output logic [Inst_Size-1:0] x16, x17, x18, x19, x20, x21, x22, x23,
    output logic [Inst_Size-1:0] x24, x25, x26, x27, x28, x29, x30, x31
);

    logic [6:0]                    w_opcode;
    logic [2:0]                    w_func3;
    logic [4:0]                    w_rd;
    logic                          w_we;
    imm_fmt_e                      w_fmt;
    logic [31:0][Inst_Size-1:0]    w_regs;

    assign w_opcode = Inst[6:0];
    assign w_func3  = Inst[14:12];
    assign w_rd     = Inst[11:7];
    assign w_we     = wr_en && has_rd(w_opcode);
    assign opcode   = w_opcode;

    always_comb begin
        func3 = w_func3;
        if (w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL) func3 = 3'b000;
    end

    always_comb begin
        func7 = 7'd0;
        if (w_opcode == OP_R ||
            (w_opcode == OP_IMM && (w_func3 == 3'b001 || w_func3 == 3'b101)))
            func7 = Inst[31:25];
    end

    // NOTE: the default assignment ahead of the case keeps this block latch-free.
    always_comb begin
        w_fmt = NONE;
        if (jal) begin
            w_fmt = J;
        end else begin
            case (w_opcode)
                OP_IMM, OP_LOAD, OP_JALR: w_fmt = I;
                OP_STORE:                 w_fmt = S;
                OP_BRANCH:                w_fmt = B;
                OP_JAL:                   w_fmt = J;
                OP_LUI, OP_AUIPC:         w_fmt = U;
                default:                  w_fmt = NONE;
            endcase
        end
    end

    always_comb begin
        Ext_Imm = '0;
        case (w_fmt)
            I:       Ext_Imm = {{20{Inst[31]}}, Inst[31:20]};
            S:       Ext_Imm = {{20{Inst[31]}}, Inst[31:25], Inst[11:7]};
            B:       Ext_Imm = {{20{Inst[31]}}, Inst[7], Inst[30:25], Inst[11:8], 1'b0};
            J:       Ext_Imm = {{12{Inst[31]}}, Inst[19:12], Inst[20], Inst[30:21], 1'b0};
            U:       Ext_Imm = Imm_Sel ? {Inst[31:12], 12'b0} : '0;
            default: Ext_Imm = '0;
        endcase
    end

    reg_file #(.Inst_Size(Inst_Size)) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_we),
        .i_waddr  (w_rd),
        .i_wdata  (write_data),
        .i_raddr1 (Inst[19:15]),
        .i_raddr2 (Inst[24:20]),
        .o_rdata1 (rs1_data),
        .o_rdata2 (rs2_data),
        .o_regs   (w_regs)
    );

    assign x0  = w_regs[0];  assign x1  = w_regs[1];  assign x2  = w_regs[2];  assign x3  = w_regs[3];
    assign x4  = w_regs[4];  assign x5  = w_regs[5];  assign x6  = w_regs[6];  assign x7  = w_regs[7];
    assign x8  = w_regs[8];  assign x9  = w_regs[9];  assign x10 = w_regs[10]; assign x11 = w_regs[11];
    assign x12 = w_regs[12]; assign x13 = w_regs[13]; assign x14 = w_regs[14]; assign x15 = w_regs[15];
    assign x16 = w_regs[16]; assign x17 = w_regs[17]; assign x18 = w_regs[18]; assign x19 = w_regs[19];
    assign x20 = w_regs[20]; assign x21 = w_regs[21]; assign x22 = w_regs[22]; assign x23 = w_regs[23];
    assign x24 = w_regs[24]; assign x25 = w_regs[25]; assign x26 = w_regs[26]; assign x27 = w_regs[27];
    assign x28 = w_regs[28]; assign x29 = w_regs[29]; assign x30 = w_regs[30]; assign x31 = w_regs[31];

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// checked against an array-based architectural model of decode and register state.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Inst = '0, write_data = '0;
    logic        wr_en = 1'b0, Imm_Sel = 1'b0, jal = 1'b0;
    logic [31:0] rs1_data, rs2_data, Ext_Imm;
    logic [6:0]  func7, opcode;
    logic [2:0]  func3;
    logic [31:0] xs [32];

    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_regs [32];

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .Inst(Inst), .wr_en(wr_en), .Imm_Sel(Imm_Sel), .jal(jal),
        .write_data(write_data), .rs1_data(rs1_data), .rs2_data(rs2_data), .Ext_Imm(Ext_Imm),
        .func7(func7), .func3(func3), .opcode(opcode),
        .x0(xs[0]),   .x1(xs[1]),   .x2(xs[2]),   .x3(xs[3]),   .x4(xs[4]),   .x5(xs[5]),
        .x6(xs[6]),   .x7(xs[7]),   .x8(xs[8]),   .x9(xs[9]),   .x10(xs[10]), .x11(xs[11]),
        .x12(xs[12]), .x13(xs[13]), .x14(xs[14]), .x15(xs[15]), .x16(xs[16]), .x17(xs[17]),
        .x18(xs[18]), .x19(xs[19]), .x20(xs[20]), .x21(xs[21]), .x22(xs[22]), .x23(xs[23]),
        .x24(xs[24]), .x25(xs[25]), .x26(xs[26]), .x27(xs[27]), .x28(xs[28]), .x29(xs[29]),
        .x30(xs[30]), .x31(xs[31])
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] sext(input int unsigned v, input int bits);
        int unsigned m = (32'd1 << bits) - 1;
        v = v & m;
        if (v >= (32'd1 << (bits - 1))) return v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic isel, input logic j);
        int unsigned op = ins & 32'h7F;
        int unsigned b31 = ins >> 31;
        if (j || op == 32'h6F)
            return sext((b31 << 20) | (((ins >> 12) & 32'hFF) << 12) |
                        (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3FF) << 1), 21);
        if (op == 32'h13 || op == 32'h03 || op == 32'h67) return sext(ins >> 20, 12);
        if (op == 32'h23) return sext(((ins >> 25) << 5) | ((ins >> 7) & 32'h1F), 12);
        if (op == 32'h63)
            return sext((b31 << 12) | (((ins >> 7) & 1) << 11) |
                        (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1), 13);
        if (op == 32'h37 || op == 32'h17) return isel ? (ins & 32'hFFFF_F000) : 32'd0;
        return 32'd0;
    endfunction

    function automatic logic [2:0] ref_f3(input logic [31:0] ins);
        int unsigned op = ins & 32'h7F;
        if (op == 32'h37 || op == 32'h17 || op == 32'h6F) return 3'd0;
        return 3'((ins >> 12) & 7);
    endfunction

    function automatic logic [6:0] ref_f7(input logic [31:0] ins);
        int unsigned op = ins & 32'h7F;
        int unsigned f3 = (ins >> 12) & 7;
        if (op == 32'h33 || (op == 32'h13 && (f3 == 1 || f3 == 5))) return 7'(ins >> 25);
        return 7'd0;
    endfunction

    function automatic logic ref_writes(input logic [31:0] ins, input logic we);
        int unsigned op = ins & 32'h7F;
        return we && (((ins >> 7) & 32'h1F) != 0) && op != 32'h23 && op != 32'h63;
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned a);
        if (a == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (ref_writes(Inst, wr_en) && ((Inst >> 7) & 32'h1F) == a) return write_data;
`endif
        return ref_regs[a];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] ins, input logic [31:0] wd, input logic we,
                         input logic isel, input logic j);
        @(negedge clk);
        Inst = ins; write_data = wd; wr_en = we; Imm_Sel = isel; jal = j;
        #1;
    endtask

    task automatic tick();
        if (rst_n && ref_writes(Inst, wr_en)) ref_regs[(Inst >> 7) & 32'h1F] = write_data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        #2;
        for (int i = 0; i < 32; i++) begin
            total++;
            if (xs[i] !== 32'd0) begin
                bad++; $display("FAIL reset_x%0d got=%h exp=%h", i, xs[i], 32'd0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_itype();
        drive(32'h0000_0313, 32'h313, 1'b1, 1'b0, 1'b0);
        total++; if (opcode !== 7'b0010011) begin bad++; $display("FAIL itype_opcode got=%b exp=0010011", opcode); end
        total++; if (func3 !== 3'd0)        begin bad++; $display("FAIL itype_func3 got=%b exp=000", func3); end
        total++; if (func7 !== 7'd0)        begin bad++; $display("FAIL itype_func7 got=%h exp=00", func7); end
        total++; if (Ext_Imm !== 32'd0)     begin bad++; $display("FAIL itype_imm got=%h exp=0", Ext_Imm); end
        tick();
        total++; if (xs[6] !== 32'h313)     begin bad++; $display("FAIL itype_x6 got=%h exp=313", xs[6]); end
    endtask

    task automatic test_rtype();
        drive(32'h0000_2333, 32'h313, 1'b1, 1'b0, 1'b0);
        total++; if (func3 !== 3'b010)  begin bad++; $display("FAIL rtype_func3 got=%b exp=010", func3); end
        total++; if (func7 !== 7'd0)    begin bad++; $display("FAIL rtype_func7 got=%h exp=00", func7); end
        total++; if (Ext_Imm !== 32'd0) begin bad++; $display("FAIL rtype_imm got=%h exp=0", Ext_Imm); end
        tick();
        total++; if (xs[6] !== 32'h313) begin bad++; $display("FAIL rtype_x6 got=%h exp=313", xs[6]); end
        drive(32'h4000_2333, 32'h313, 1'b1, 1'b0, 1'b0);
        total++; if (func7 !== 7'h20)   begin bad++; $display("FAIL rtype_func7_sub got=%h exp=20", func7); end
        tick();
    endtask

    task automatic test_jal();
        drive(32'h0000_036F, 32'hCAFE_0001, 1'b1, 1'b0, 1'b1);
        total++; if (opcode !== 7'b1101111) begin bad++; $display("FAIL jal_opcode got=%b exp=1101111", opcode); end
        total++; if (func3 !== 3'd0)        begin bad++; $display("FAIL jal_func3 got=%b exp=000", func3); end
        total++; if (Ext_Imm !== 32'd0)     begin bad++; $display("FAIL jal_imm got=%h exp=0", Ext_Imm); end
        tick();
        total++; if (xs[6] !== 32'hCAFE_0001) begin bad++; $display("FAIL jal_x6 got=%h exp=cafe0001", xs[6]); end
        drive(32'h8000_006F, 32'h0, 1'b0, 1'b0, 1'b1);
        total++; if (Ext_Imm !== 32'hFFF0_0000) begin bad++; $display("FAIL jal_imm_neg got=%h exp=fff00000", Ext_Imm); end
        drive(32'h0000_0313, 32'h313, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_no_rd();
        logic [31:0] snap [32];
        for (int i = 0; i < 32; i++) snap[i] = ref_regs[i];
        drive(32'h0011_4063, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);
        total++; if (func3 !== 3'b100)  begin bad++; $display("FAIL branch_func3 got=%b exp=100", func3); end
        total++; if (Ext_Imm !== 32'd0) begin bad++; $display("FAIL branch_imm got=%h exp=0", Ext_Imm); end
        tick();
        drive(32'h0000_A023, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);
        total++; if (func3 !== 3'b010)  begin bad++; $display("FAIL store_func3 got=%b exp=010", func3); end
        total++; if (Ext_Imm !== 32'd0) begin bad++; $display("FAIL store_imm got=%h exp=0", Ext_Imm); end
        tick();
        for (int i = 0; i < 32; i++) begin
            total++;
            if (xs[i] !== snap[i]) begin bad++; $display("FAIL no_rd_x%0d got=%h exp=%h", i, xs[i], snap[i]); end
        end
        total++; if (xs[6] !== 32'h313) begin bad++; $display("FAIL no_rd_x6 got=%h exp=313", xs[6]); end
    endtask

    task automatic test_lui();
        drive(32'h0000_F337, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (func3 !== 3'd0)    begin bad++; $display("FAIL lui_func3 got=%b exp=000", func3); end
        total++; if (func7 !== 7'd0)    begin bad++; $display("FAIL lui_func7 got=%h exp=00", func7); end
        total++; if (Ext_Imm !== 32'd0) begin bad++; $display("FAIL lui_imm_off got=%h exp=0", Ext_Imm); end
        drive(32'h0000_F337, 32'h0, 1'b0, 1'b1, 1'b0);
        total++; if (Ext_Imm !== 32'h0000_F000) begin bad++; $display("FAIL lui_imm_on got=%h exp=0000f000", Ext_Imm); end
    endtask

    task automatic test_x0_and_bypass();
        logic [31:0] ins;
        drive(32'h0000_0013, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);   // addi x0, x0, 0
        tick();
        total++; if (xs[0] !== 32'd0)    begin bad++; $display("FAIL x0_port got=%h exp=0", xs[0]); end
        total++; if (rs1_data !== 32'd0) begin bad++; $display("FAIL x0_read got=%h exp=0", rs1_data); end
        drive(32'h0010_0393, 32'h7777_0007, 1'b1, 1'b0, 1'b0);   // x7 <- 0x77770007
        tick();
        ins = {12'h007, 5'd7, 3'b000, 5'd7, 7'b0010011};
        drive(ins, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        total++; if (rs1_data !== ref_read(7)) begin bad++; $display("FAIL same_cycle_read got=%h exp=%h", rs1_data, ref_read(7)); end
        total++; if (rs2_data !== ref_read(7)) begin bad++; $display("FAIL same_cycle_read2 got=%h exp=%h", rs2_data, ref_read(7)); end
        total++; if (xs[7] !== 32'h7777_0007)  begin bad++; $display("FAIL xport_no_bypass got=%h exp=77770007", xs[7]); end
        tick();
        total++; if (xs[7] !== 32'h1234_5678)  begin bad++; $display("FAIL x7_after_edge got=%h exp=12345678", xs[7]); end
    endtask

    task automatic test_async_reset();
        drive(32'h0010_0F93, 32'hAAAA_001F, 1'b1, 1'b0, 1'b0);   // x31
        tick();
        drive(32'h0000_0313, 32'h313, 1'b1, 1'b0, 1'b0);         // x6
        tick();
        total++; if (xs[31] !== 32'hAAAA_001F) begin bad++; $display("FAIL preload_x31 got=%h exp=aaaa001f", xs[31]); end
        drive(32'h0000_02B3, 32'h5A5A_5A5A, 1'b1, 1'b0, 1'b0);   // pending write to x5
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            ref_regs[i] = '0;
            total++;
            if (xs[i] !== 32'd0) begin bad++; $display("FAIL async_clear_x%0d got=%h exp=0", i, xs[i]); end
        end
        tick();
        total++; if (xs[5] !== 32'd0) begin bad++; $display("FAIL reset_over_write got=%h exp=0", xs[5]); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7B};
        logic [31:0] ins;
        logic        we, isel, j;
        for (int n = 0; n < 300; n++) begin
            ins  = {$urandom() >> 7, ops[$urandom_range(0, 9)]};
            we   = 1'($urandom_range(0, 3) != 0);
            isel = 1'($urandom());
            j    = ($urandom_range(0, 7) == 0);
            drive(ins, $urandom(), we, isel, j);
            total++; if (opcode !== ins[6:0])  begin bad++; $display("FAIL rnd_opcode inst=%h got=%h exp=%h", ins, opcode, ins[6:0]); end
            total++; if (func3 !== ref_f3(ins)) begin bad++; $display("FAIL rnd_func3 inst=%h got=%h exp=%h", ins, func3, ref_f3(ins)); end
            total++; if (func7 !== ref_f7(ins)) begin bad++; $display("FAIL rnd_func7 inst=%h got=%h exp=%h", ins, func7, ref_f7(ins)); end
            total++; if (Ext_Imm !== ref_imm(ins, isel, j)) begin
                bad++; $display("FAIL rnd_imm inst=%h jal=%b sel=%b got=%h exp=%h", ins, j, isel, Ext_Imm, ref_imm(ins, isel, j));
            end
            total++; if (rs1_data !== ref_read(ins[19:15])) begin bad++; $display("FAIL rnd_rs1 inst=%h got=%h exp=%h", ins, rs1_data, ref_read(ins[19:15])); end
            total++; if (rs2_data !== ref_read(ins[24:20])) begin bad++; $display("FAIL rnd_rs2 inst=%h got=%h exp=%h", ins, rs2_data, ref_read(ins[24:20])); end
            tick();
            for (int i = 0; i < 32; i++) begin
                total++;
                if (xs[i] !== ref_regs[i]) begin bad++; $display("FAIL rnd_x%0d iter=%0d got=%h exp=%h", i, n, xs[i], ref_regs[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_rtype();
        test_jal();
        test_no_rd();
        test_lui();
        test_x0_and_bypass();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
